// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter.
// FSM state encoding, default parameters and the counter saturation value.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 50_000_000;

  // All-ones value of a w-bit counter, used as the saturation ceiling.
  function automatic logic [63:0] CNT_MAX(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input with a previous-value
// flop, giving the synchronised level plus single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic sig_s,
  output logic rise_p,
  output logic fall_p
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s  = sync_q[SYNC_STAGES-1];
  assign rise_p = sig_s & ~prev_q;
  assign fall_p = ~sig_s & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous square wave in clk_i cycles,
// with sticky loss-of-signal. Optional high-time measurement: DUTY_MEAS_EN.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] SAT     = CNT_W'(CNT_MAX(CNT_W));
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic sig_s, rise, fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk_i),
    .rst    (rst_i),
    .sig    (sig_i),
    .sig_s  (sig_s),
    .rise_p (rise),
    .fall_p (fall)
  );

  // state is left visible by name so checkers can bind to it
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] period_q, period_n;
  logic             valid_q, valid_n;
  logic             timeout_q, timeout_n;

  assign cnt_inc = (cnt == SAT) ? SAT : cnt + 1'b1;

  // Priority: en_i low, then rise, then timeout (reset handled in the register).
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    period_n  = period_q;
    valid_n   = 1'b0;
    timeout_n = timeout_q;
    if (!en_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (rise) state_n = MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period_n = cnt_inc;
            valid_n  = 1'b1;
            cnt_n    = '0;
          end else if (cnt == TO_LAST) begin
            state_n   = STALL;
            timeout_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        STALL: begin
          if (rise) begin
            state_n   = MEASURE;
            cnt_n     = '0;
            timeout_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      period_q  <= period_n;
      valid_q   <= valid_n;
      timeout_q <= timeout_n;
    end
  end

  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] hcnt, high_lat, high_q;

  // hcnt restarts at 1 on a rise so the rise cycle itself is counted as high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt     <= '0;
      high_lat <= '0;
      high_q   <= '0;
    end else begin
      if (rise)       hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (sig_s) hcnt <= (hcnt == SAT) ? SAT : hcnt + 1'b1;
      if (fall)    high_lat <= hcnt;
      if (valid_n) high_q   <= high_lat;
    end
  end

  assign high_o = high_q;
`else
  logic unused_duty;
  assign unused_duty = sig_s ^ fall;
  assign high_o      = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (CNT_W=16, SYNC_STAGES=2, TIMEOUT_CYC=100).
// High-time expectations follow DUTY_MEAS_EN when it is defined.
module tb_clk_period_meter;
  import clk_meas_pkg::*;

`ifdef DUTY_MEAS_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i  = 1'b0;
  logic        sig_i = 1'b0;
  logic [15:0] period_o, high_o;
  logic        valid_o, timeout_o;

  int n_vec = 0;
  int n_err = 0;

  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT_CYC(100)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .sig_i     (sig_i),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard capture of every valid_o pulse
  logic [15:0] vq[$];
  logic [15:0] hq[$];
  int          tq[$];
  logic [15:0] exp_q[$];
  logic [15:0] hexp_q[$];
  int cyc = 0, to_cyc = -1, dbl = 0;
  logic prev_v = 1'b0, prev_to = 1'b0;

  always @(negedge clk_i) begin
    cyc = cyc + 1;
    if (valid_o === 1'b1) begin
      vq.push_back(period_o);
      hq.push_back(high_o);
      tq.push_back(cyc);
      if (prev_v) dbl = dbl + 1;
    end
    if (timeout_o === 1'b1 && !prev_to) to_cyc = cyc;
    prev_v  = valid_o;
    prev_to = timeout_o;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic clear_sb();
    vq.delete(); hq.delete(); tq.delete(); exp_q.delete(); hexp_q.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sig_i = ~sig_i;
      @(negedge clk_i);
      n_vec++; if (period_o !== 16'd0) begin n_err++; $display("FAIL reset_period got %0d want 0", period_o); end
      n_vec++; if (high_o !== 16'd0) begin n_err++; $display("FAIL reset_high got %0d want 0", high_o); end
      n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_o); end
      n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout_o); end
    end
    rst_i = 1'b0; en_i = 1'b0; sig_i = 1'b0;
    wait_cyc(5);
    n_vec++; if (vq.size() != 0) begin n_err++; $display("FAIL reset_no_valid got %0d pulses want 0", vq.size()); end
  endtask

  task automatic test_periodic();
    clear_sb();
    en_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_cyc(10);
      sig_i = ~sig_i;
    end
    wait_cyc(5);
    n_vec++; if (vq.size() != 4) begin n_err++; $display("FAIL periodic_count got %0d want 4", vq.size()); end
    for (int i = 0; i < vq.size(); i++) begin
      n_vec++; if (vq[i] !== 16'd20) begin n_err++; $display("FAIL periodic_period[%0d] got %0d want 20", i, vq[i]); end
      n_vec++; if (hq[i] !== (DUTY ? 16'd10 : 16'd0)) begin n_err++; $display("FAIL periodic_high[%0d] got %0d want %0d", i, hq[i], DUTY ? 10 : 0); end
      if (i > 0) begin
        n_vec++; if (tq[i] - tq[i-1] != 20) begin n_err++; $display("FAIL periodic_spacing[%0d] got %0d want 20", i, tq[i] - tq[i-1]); end
      end
    end
    n_vec++; if (dbl != 0) begin n_err++; $display("FAIL periodic_pulse_width got %0d wide pulses want 0", dbl); end
  endtask

  task automatic test_rate_change();
    clear_sb();
    exp_q = '{16'd17, 16'd14, 16'd14, 16'd14};
    hexp_q = DUTY ? '{16'd10, 16'd7, 16'd7, 16'd7} : '{16'd0, 16'd0, 16'd0, 16'd0};
    wait_cyc(5);
    sig_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wait_cyc(7);
      sig_i = ~sig_i;
    end
    wait_cyc(5);
    n_vec++; if (vq.size() != exp_q.size()) begin n_err++; $display("FAIL rate_count got %0d want %0d", vq.size(), exp_q.size()); end
    for (int i = 0; i < vq.size() && i < exp_q.size(); i++) begin
      n_vec++; if (vq[i] !== exp_q[i]) begin n_err++; $display("FAIL rate_period[%0d] got %0d want %0d", i, vq[i], exp_q[i]); end
      n_vec++; if (hq[i] !== hexp_q[i]) begin n_err++; $display("FAIL rate_high[%0d] got %0d want %0d", i, hq[i], hexp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int last_v;
    last_v = (tq.size() > 0) ? tq[tq.size()-1] : 0;
    clear_sb();
    to_cyc = -1;
    wait_cyc(5);
    sig_i = 1'b0;
    wait_cyc(150);
    n_vec++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL timeout_set got %b want 1", timeout_o); end
    n_vec++; if (to_cyc - last_v != 100) begin n_err++; $display("FAIL timeout_delay got %0d want 100", to_cyc - last_v); end
    n_vec++; if (period_o !== 16'd14) begin n_err++; $display("FAIL timeout_hold_period got %0d want 14", period_o); end
    sig_i = 1'b1;
    wait_cyc(10);
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL timeout_clear got %b want 0", timeout_o); end
    n_vec++; if (vq.size() != 0) begin n_err++; $display("FAIL timeout_rearm_valid got %0d pulses want 0", vq.size()); end
    sig_i = 1'b0;
    wait_cyc(10);
    sig_i = 1'b1;
    wait_cyc(5);
    n_vec++; if (vq.size() != 1) begin n_err++; $display("FAIL timeout_resume_count got %0d want 1", vq.size()); end
    else begin
      n_vec++; if (vq[0] !== 16'd20) begin n_err++; $display("FAIL timeout_resume_period got %0d want 20", vq[0]); end
      n_vec++; if (hq[0] !== (DUTY ? 16'd10 : 16'd0)) begin n_err++; $display("FAIL timeout_resume_high got %0d want %0d", hq[0], DUTY ? 10 : 0); end
    end
  endtask

  task automatic test_enable_drop();
    clear_sb();
    wait_cyc(5);
    sig_i = 1'b0;
    wait_cyc(5);
    en_i = 1'b0;
    wait_cyc(1);
    en_i = 1'b1;
    wait_cyc(5);
    sig_i = 1'b1;
    wait_cyc(10);
    n_vec++; if (vq.size() != 0) begin n_err++; $display("FAIL endrop_no_valid got %0d pulses want 0", vq.size()); end
    n_vec++; if (period_o !== 16'd20) begin n_err++; $display("FAIL endrop_hold_period got %0d want 20", period_o); end
    sig_i = 1'b0;
    wait_cyc(10);
    sig_i = 1'b1;
    wait_cyc(5);
    n_vec++; if (vq.size() != 1) begin n_err++; $display("FAIL endrop_resume_count got %0d want 1", vq.size()); end
    else begin
      n_vec++; if (vq[0] !== 16'd20) begin n_err++; $display("FAIL endrop_resume_period got %0d want 20", vq[0]); end
    end
  endtask

  task automatic test_reset_on_rise();
    clear_sb();
    wait_cyc(5);
    sig_i = 1'b0;
    wait_cyc(10);
    sig_i = 1'b1;
    wait_cyc(2);
    rst_i = 1'b1;
    wait_cyc(1);
    rst_i = 1'b0;
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rstrise_valid got %b want 0", valid_o); end
    n_vec++; if (period_o !== 16'd0) begin n_err++; $display("FAIL rstrise_period got %0d want 0", period_o); end
    n_vec++; if (high_o !== 16'd0) begin n_err++; $display("FAIL rstrise_high got %0d want 0", high_o); end
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL rstrise_timeout got %b want 0", timeout_o); end
    n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL rstrise_state got %0d want %0d", dut.state, IDLE); end
    wait_cyc(8);
    n_vec++; if (vq.size() != 0) begin n_err++; $display("FAIL rstrise_no_valid got %0d pulses want 0", vq.size()); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_rate_change();
    test_timeout();
    test_enable_drop();
    test_reset_on_rise();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
